// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU header: exception causes, control-op encodings, controller states and the
// default exception vector.
package pipe_ctrl_pkg;

    localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
    localparam logic [2:0] ISA_EXP_UNDEF_INSN = 3'd1;
    localparam logic [2:0] ISA_EXP_MISALIGN   = 3'd2;
    localparam logic [2:0] ISA_EXP_BUS_ERR    = 3'd3;
    localparam logic [2:0] ISA_EXP_SYSCALL    = 3'd4;
    localparam logic [2:0] ISA_EXP_BREAK      = 3'd5;

    localparam logic [1:0] CTRL_OP_NONE  = 2'd0;
    localparam logic [1:0] CTRL_OP_ERET  = 2'd1;
    localparam logic [1:0] CTRL_OP_FENCE = 2'd2;

    localparam logic [31:0] EXP_VECTOR_DEFAULT = 32'h0000_0004;

    typedef enum logic {
        StRun = 1'b0,
        StExc = 1'b1
    } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall and flush, fetch redirect, and
// the saved exception PC/cause across the RUN/EXC state machine.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXP_VECTOR = EXP_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_busy,
    input  logic        mem_busy,
    input  logic        ld_hazard,
    input  logic        br_taken,
    input  logic [31:0] br_addr,
    input  logic        mem_en,
    input  logic [31:0] mem_pc,
    input  logic [2:0]  mem_exp_code,
    input  logic [1:0]  mem_ctrl_op,
    output logic        if_stall,
    output logic        id_stall,
    output logic        ex_stall,
    output logic        mem_stall,
    output logic        if_flush,
    output logic        id_flush,
    output logic        ex_flush,
    output logic        mem_flush,
    output logic        set_pc,
    output logic [31:0] new_pc,
    output logic [31:0] epc,
    output logic [2:0]  exp_code,
    output logic        in_exc
);

    pipe_state_e state;

    logic       global_stall;
    logic       exc_req;
    logic       eret_req;
    logic       take_exc;
    logic       do_eret;
    logic [2:0] cause;

    assign global_stall = if_busy | mem_busy;
    assign exc_req      = mem_en & (mem_exp_code != ISA_EXP_NO_EXP);
    assign eret_req     = mem_en & (mem_ctrl_op == CTRL_OP_ERET) & ~exc_req;
    // An ERET outside an exception handler is itself an illegal instruction.
    assign take_exc     = exc_req | (eret_req & (state == StRun));
    assign do_eret      = eret_req & (state == StExc);
    assign cause        = exc_req ? mem_exp_code : ISA_EXP_UNDEF_INSN;

    always_comb begin
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        ex_stall  = 1'b0;
        mem_stall = 1'b0;
        if_flush  = 1'b0;
        id_flush  = 1'b0;
        ex_flush  = 1'b0;
        mem_flush = 1'b0;
        set_pc    = 1'b0;
        new_pc    = 32'h0;
        if (global_stall) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_stall = 1'b1;
        end else if (take_exc) begin
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            mem_flush = 1'b1;
            set_pc    = 1'b1;
            new_pc    = EXP_VECTOR;
        end else if (do_eret) begin
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            mem_flush = 1'b1;
            set_pc    = 1'b1;
            new_pc    = epc;
        end else if (ld_hazard) begin
            // Branch in ID is dropped; it re-resolves once the load-use bubble clears.
            if_stall = 1'b1;
            id_flush = 1'b1;
        end else if (br_taken) begin
            if_flush = 1'b1;
            set_pc   = 1'b1;
            new_pc   = br_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= StRun;
            epc      <= 32'h0;
            exp_code <= ISA_EXP_NO_EXP;
            in_exc   <= 1'b0;
        end else if (!global_stall) begin
            if (take_exc) begin
                state    <= StExc;
                epc      <= mem_pc;
                exp_code <= cause;
                in_exc   <= 1'b1;
            end else if (do_eret) begin
                state  <= StRun;
                in_exc <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: table of single-cycle priority vectors from RUN, then
// hand-written multi-cycle sequences for exception entry/return, hazards and reset.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_busy = 1'b0, mem_busy = 1'b0, ld_hazard = 1'b0, br_taken = 1'b0;
    logic [31:0] br_addr = 32'h0;
    logic        mem_en = 1'b0;
    logic [31:0] mem_pc = 32'h0;
    logic [2:0]  mem_exp_code = 3'd0;
    logic [1:0]  mem_ctrl_op = 2'd0;
    logic        if_stall, id_stall, ex_stall, mem_stall;
    logic        if_flush, id_flush, ex_flush, mem_flush;
    logic        set_pc;
    logic [31:0] new_pc, epc;
    logic [2:0]  exp_code;
    logic        in_exc;

    int checks = 0;
    int errors = 0;

    pipe_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .if_busy      (if_busy),
        .mem_busy     (mem_busy),
        .ld_hazard    (ld_hazard),
        .br_taken     (br_taken),
        .br_addr      (br_addr),
        .mem_en       (mem_en),
        .mem_pc       (mem_pc),
        .mem_exp_code (mem_exp_code),
        .mem_ctrl_op  (mem_ctrl_op),
        .if_stall     (if_stall),
        .id_stall     (id_stall),
        .ex_stall     (ex_stall),
        .mem_stall    (mem_stall),
        .if_flush     (if_flush),
        .id_flush     (id_flush),
        .ex_flush     (ex_flush),
        .mem_flush    (mem_flush),
        .set_pc       (set_pc),
        .new_pc       (new_pc),
        .epc          (epc),
        .exp_code     (exp_code),
        .in_exc       (in_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        if_busy;
        logic        mem_busy;
        logic        ld_hazard;
        logic        br_taken;
        logic [31:0] br_addr;
        logic        mem_en;
        logic [2:0]  code;
        logic [1:0]  op;
        logic [3:0]  e_stall;   // {if,id,ex,mem}
        logic [3:0]  e_flush;   // {if,id,ex,mem}
        logic        e_set_pc;
        logic [31:0] e_new_pc;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    function automatic logic [3:0] stall_v();
        return {if_stall, id_stall, ex_stall, mem_stall};
    endfunction

    function automatic logic [3:0] flush_v();
        return {if_flush, id_flush, ex_flush, mem_flush};
    endfunction

    task automatic idle_inputs();
        if_busy = 1'b0; mem_busy = 1'b0; ld_hazard = 1'b0; br_taken = 1'b0;
        br_addr = 32'h0; mem_en = 1'b0; mem_pc = 32'h0;
        mem_exp_code = ISA_EXP_NO_EXP; mem_ctrl_op = CTRL_OP_NONE;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    // Let the current inputs be captured at the next rising edge, then settle at negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{0, 0, 0, 0, 32'h0,  0, 3'd0, CTRL_OP_NONE, 4'b0000, 4'b0000, 0, 32'h0};
        vecs[1]  = '{1, 0, 0, 1, 32'h80, 0, 3'd0, CTRL_OP_NONE, 4'b1111, 4'b0000, 0, 32'h0};
        vecs[2]  = '{0, 1, 1, 0, 32'h0,  1, 3'd3, CTRL_OP_NONE, 4'b1111, 4'b0000, 0, 32'h0};
        vecs[3]  = '{0, 0, 1, 0, 32'h0,  0, 3'd0, CTRL_OP_NONE, 4'b1000, 4'b0100, 0, 32'h0};
        vecs[4]  = '{0, 0, 0, 1, 32'h44, 0, 3'd0, CTRL_OP_NONE, 4'b0000, 4'b1000, 1, 32'h44};
        vecs[5]  = '{0, 0, 1, 1, 32'h44, 0, 3'd0, CTRL_OP_NONE, 4'b1000, 4'b0100, 0, 32'h0};
        vecs[6]  = '{0, 0, 1, 1, 32'h44, 1, 3'd4, CTRL_OP_NONE, 4'b0000, 4'b1111, 1, 32'h4};
        vecs[7]  = '{0, 0, 1, 1, 32'h44, 1, 3'd0, CTRL_OP_ERET, 4'b0000, 4'b1111, 1, 32'h4};
        vecs[8]  = '{0, 0, 0, 0, 32'h0,  1, 3'd5, CTRL_OP_ERET, 4'b0000, 4'b1111, 1, 32'h4};
        vecs[9]  = '{0, 0, 0, 0, 32'h0,  0, 3'd2, CTRL_OP_ERET, 4'b0000, 4'b0000, 0, 32'h0};
        vecs[10] = '{0, 0, 0, 1, 32'h9C, 1, 3'd0, CTRL_OP_FENCE, 4'b0000, 4'b1000, 1, 32'h9C};
        vecs[11] = '{1, 1, 0, 0, 32'h0,  1, 3'd2, CTRL_OP_NONE, 4'b1111, 4'b0000, 0, 32'h0};

        idle_inputs();
        #2;
        chk("reset_epc", epc, 32'h0);
        chk("reset_exp_code", {29'h0, exp_code}, {29'h0, ISA_EXP_NO_EXP});
        chk("reset_in_exc", {31'h0, in_exc}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            pulse_reset();
            if_busy = vecs[i].if_busy; mem_busy = vecs[i].mem_busy;
            ld_hazard = vecs[i].ld_hazard; br_taken = vecs[i].br_taken;
            br_addr = vecs[i].br_addr; mem_en = vecs[i].mem_en;
            mem_exp_code = vecs[i].code; mem_ctrl_op = vecs[i].op;
            mem_pc = 32'h1000 + 32'(i);
            #1;
            chk($sformatf("vec%0d_stall", i), {28'h0, stall_v()}, {28'h0, vecs[i].e_stall});
            chk($sformatf("vec%0d_flush", i), {28'h0, flush_v()}, {28'h0, vecs[i].e_flush});
            chk($sformatf("vec%0d_set_pc", i), {31'h0, set_pc}, {31'h0, vecs[i].e_set_pc});
            chk($sformatf("vec%0d_new_pc", i), new_pc, vecs[i].e_new_pc);
        end

        // Exception entry then return.
        @(negedge clk);
        idle_inputs();
        pulse_reset();
        mem_en = 1'b1; mem_exp_code = 3'd2; mem_pc = 32'h100;
        #1;
        chk("exc_flush", {28'h0, flush_v()}, 32'hF);
        chk("exc_set_pc", {31'h0, set_pc}, 32'h1);
        chk("exc_new_pc", new_pc, 32'h4);
        step();
        idle_inputs();
        #1;
        chk("exc_epc", epc, 32'h100);
        chk("exc_code", {29'h0, exp_code}, 32'h2);
        chk("exc_in_exc", {31'h0, in_exc}, 32'h1);
        chk("exc_idle_set_pc", {31'h0, set_pc}, 32'h0);
        mem_en = 1'b1; mem_ctrl_op = CTRL_OP_ERET; mem_pc = 32'h180;
        #1;
        chk("eret_flush", {28'h0, flush_v()}, 32'hF);
        chk("eret_set_pc", {31'h0, set_pc}, 32'h1);
        chk("eret_new_pc", new_pc, 32'h100);
        step();
        idle_inputs();
        #1;
        chk("eret_in_exc", {31'h0, in_exc}, 32'h0);
        chk("eret_epc_kept", epc, 32'h100);

        // Load-use hazard suppresses a branch, which is taken the following cycle.
        ld_hazard = 1'b1; br_taken = 1'b1; br_addr = 32'h40;
        #1;
        chk("ld_stall", {28'h0, stall_v()}, 32'h8);
        chk("ld_flush", {28'h0, flush_v()}, 32'h4);
        chk("ld_set_pc", {31'h0, set_pc}, 32'h0);
        step();
        ld_hazard = 1'b0;
        #1;
        chk("br_flush", {28'h0, flush_v()}, 32'h8);
        chk("br_set_pc", {31'h0, set_pc}, 32'h1);
        chk("br_new_pc", new_pc, 32'h40);
        step();
        idle_inputs();

        // Bus stall holds off a pending exception.
        mem_busy = 1'b1; mem_en = 1'b1; mem_exp_code = 3'd2; mem_pc = 32'h300;
        #1;
        chk("busy_stall", {28'h0, stall_v()}, 32'hF);
        chk("busy_flush", {28'h0, flush_v()}, 32'h0);
        chk("busy_set_pc", {31'h0, set_pc}, 32'h0);
        step();
        chk("busy_epc_held", epc, 32'h100);
        chk("busy_in_exc", {31'h0, in_exc}, 32'h0);
        mem_busy = 1'b0;
        #1;
        chk("rel_flush", {28'h0, flush_v()}, 32'hF);
        chk("rel_new_pc", new_pc, 32'h4);
        step();
        idle_inputs();
        #1;
        chk("rel_epc", epc, 32'h300);
        chk("rel_code", {29'h0, exp_code}, 32'h2);
        chk("rel_in_exc", {31'h0, in_exc}, 32'h1);

        // Nested exception overwrites epc/cause and stays in EXC.
        mem_en = 1'b1; mem_exp_code = ISA_EXP_BREAK; mem_pc = 32'h500;
        #1;
        chk("nest_new_pc", new_pc, 32'h4);
        step();
        idle_inputs();
        #1;
        chk("nest_epc", epc, 32'h500);
        chk("nest_code", {29'h0, exp_code}, {29'h0, ISA_EXP_BREAK});
        chk("nest_in_exc", {31'h0, in_exc}, 32'h1);

        // Asynchronous reset mid-exception, well away from any clock edge.
        reset = 1'b1;
        #1;
        chk("areset_in_exc", {31'h0, in_exc}, 32'h0);
        chk("areset_epc", epc, 32'h0);
        chk("areset_code", {29'h0, exp_code}, {29'h0, ISA_EXP_NO_EXP});
        reset = 1'b0;
        #1;

        // ERET outside an exception is an illegal instruction.
        mem_en = 1'b1; mem_ctrl_op = CTRL_OP_ERET; mem_pc = 32'h200;
        #1;
        chk("bad_eret_flush", {28'h0, flush_v()}, 32'hF);
        chk("bad_eret_new_pc", new_pc, 32'h4);
        step();
        idle_inputs();
        #1;
        chk("bad_eret_code", {29'h0, exp_code}, {29'h0, ISA_EXP_UNDEF_INSN});
        chk("bad_eret_epc", epc, 32'h200);
        chk("bad_eret_in_exc", {31'h0, in_exc}, 32'h1);
        chk("idle_new_pc", new_pc, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: EXP_VECTOR, default 32'h0000_0004, exception handler entry address.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 if_busy  in  1  fetch bus not ready.
REQ-005 mem_busy  in  1  data bus not ready.
REQ-006 ld_hazard  in  1  load-use hazard detected in ID.
REQ-007 br_taken  in  1  ID resolved a taken branch or jump.
REQ-008 br_addr  in  32  target of the ID branch.
REQ-009 mem_en  in  1  MEM-stage instruction valid.
REQ-010 mem_pc  in  32  MEM-stage program counter.
REQ-011 mem_exp_code  in  3  MEM-stage exception code.
REQ-012 mem_ctrl_op  in  2  MEM-stage control operation.
REQ-013 if_stall, id_stall, ex_stall, mem_stall  out  1 each  per-stage pipeline register hold.
REQ-014 if_flush, id_flush, ex_flush, mem_flush  out  1 each  per-stage bubble insertion.
REQ-015 set_pc  out  1  redirect fetch this cycle.
REQ-016 new_pc  out  32  redirect address, valid when set_pc=1.
REQ-017 epc  out  32  saved exception PC (registered).
REQ-018 exp_code  out  3  saved exception cause (registered).
REQ-019 in_exc  out  1  1 while in state EXC.

Function
REQ-020 Stall, flush, set_pc, and new_pc SHALL be combinational from the current inputs and state; epc, exp_code, and the state SHALL be registered.
REQ-021 Global stall = if_busy | mem_busy; when 1, all four *_stall SHALL be 1 and all *_flush and set_pc SHALL be 0, with no state or epc update.
REQ-022 exc_req = mem_en & (mem_exp_code != ISA_EXP_NO_EXP); eret_req = mem_en & mem_ctrl_op==CTRL_OP_ERET & !exc_req.
REQ-023 Priority SHALL be, without global stall: exc_req > eret_req > ld_hazard > br_taken.
REQ-024 On exc_req, all four *_flush SHALL be 1, set_pc=1, and new_pc=EXP_VECTOR; at the next edge, epc<=mem_pc, exp_code<=mem_exp_code, and state<=EXC.
REQ-025 On eret_req in EXC, all *_flush SHALL be 1, set_pc=1, and new_pc=epc; at the next edge, state<=RUN.
REQ-026 On eret_req in RUN, the block SHALL act as exc_req with cause ISA_EXP_UNDEF_INSN.
REQ-027 An exception in state EXC SHALL behave per REQ-024: epc and exp_code are overwritten and the state stays EXC.
REQ-028 ld_hazard (no higher event): if_stall=1 and id_flush=1; br_taken is ignored this cycle; all other outputs 0.
REQ-029 br_taken (no higher event): if_flush=1, set_pc=1, new_pc=br_addr.
REQ-030 With no event, all outputs SHALL be 0 and new_pc SHALL be 32'h0.
REQ-031 State machine: RUN, EXC; transitions only per REQ-024 to REQ-027; in_exc = (state==EXC).

Reset
REQ-032 While reset=1: state=RUN, epc=32'h0, exp_code=ISA_EXP_NO_EXP, in_exc=0.
REQ-033 Reset asserted mid-exception SHALL return the block to RUN immediately, independent of clk.

Structure
REQ-034 ISA_EXP_* codes, CTRL_OP_* encodings, state encodings, and the EXP_VECTOR default SHALL live in the shared CPU header package.
REQ-035 The block SHALL be single-module; no sub-module.

Verification
REQ-036 mem_en=1, mem_exp_code=3'd2, mem_pc=32'h100 -> all flush=1, set_pc=1, new_pc=32'h4; next cycle epc=32'h100, exp_code=3'd2, in_exc=1.
REQ-037 In EXC, mem_en=1 with ERET -> all flush=1, new_pc=32'h100; next cycle in_exc=0.
REQ-038 ld_hazard=1 and br_taken=1 with br_addr=32'h40 -> if_stall=1, id_flush=1, set_pc=0; next cycle ld_hazard=0 -> if_flush=1, new_pc=32'h40.
REQ-039 mem_busy=1 concurrent with an exception -> all stall=1, flush=0, epc unchanged; release mem_busy -> exception is taken as in REQ-036.
REQ-040 ERET in RUN with mem_pc=32'h200 -> new_pc=32'h4; next cycle exp_code=ISA_EXP_UNDEF_INSN, epc=32'h200.
REQ-041 Asynchronous reset pulse while in EXC -> in_exc=0, epc=0, with no clock edge.
